// File: rtl/fpu_pkg.sv
// Shared encodings for the FP execute pipeline: op codes, div/sqrt FSM states,
// and the per-stage control entry carried from E1 to E3.
package fpu_pkg;
  localparam int FC_W = 3;
  localparam int RN_W = 5;
  localparam int D_W  = 32;

  localparam logic [FC_W-1:0] FC_ADD  = 3'b000;
  localparam logic [FC_W-1:0] FC_SUB  = 3'b001;
  localparam logic [FC_W-1:0] FC_MUL  = 3'b010;
  localparam logic [FC_W-1:0] FC_DIV  = 3'b011;
  localparam logic [FC_W-1:0] FC_SQRT = 3'b100;

  typedef enum logic [1:0] {DS_IDLE, DS_BUSY, DS_DONE} ds_state_e;

  // Control carried per stage: write enable, destination, and the op kind.
  // The kind bits select the E3 result source.
  typedef struct packed {
    logic            w;
    logic [RN_W-1:0] n;
    logic            ar;   // add/sub/mul, result comes from the external datapath
    logic            ds;   // div/sqrt, result comes from the sequencer latch
  } stage_t;

  function automatic logic is_ds(input logic [FC_W-1:0] fc);
    return (fc == FC_DIV) || (fc == FC_SQRT);
  endfunction
endpackage

// File: rtl/fpu_divsqrt_seq.sv
// Div/sqrt sequencer: launches the external core for the op frozen in E1,
// waits for its result with a timeout, and handles flush-driven aborts.
module fpu_divsqrt_seq
  import fpu_pkg::*;
#(
  parameter int DS_TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           e1_ds_i,
  input  logic           flush_i,
  input  logic           ds_done_i,
  input  logic [D_W-1:0] ds_r_i,
  output ds_state_e      state_o,
  output logic           ds_start_o,
  output logic           ds_abort_o,
  output logic           kill_o,
  output logic           stall_o,
  output logic           ds_err_o,
  output logic [D_W-1:0] ds_res_o
);
  localparam int TW = $clog2(DS_TIMEOUT + 1);

  ds_state_e      state_q, state_d;
  logic [TW-1:0]  cnt_q, cnt_d;
  logic           err_q, err_d;
  logic [D_W-1:0] res_q, res_d;
  logic           busy, tmo;

  // Pulses are decoded from the current state so the core sees start/abort in
  // the same cycle the condition exists; flush always outranks a late ds_done.
  always_comb begin
    busy       = (state_q == DS_BUSY);
    tmo        = busy & ~flush_i & ~ds_done_i & (cnt_q == TW'(DS_TIMEOUT - 1));
    ds_start_o = (state_q == DS_IDLE) & e1_ds_i & ~flush_i;
    ds_abort_o = busy & (flush_i | tmo);
    kill_o     = ((state_q == DS_IDLE) & e1_ds_i & flush_i) | ds_abort_o;
    state_d    = state_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    res_d      = res_q;
    case (state_q)
      DS_IDLE: if (ds_start_o) begin
        state_d = DS_BUSY;
        cnt_d   = '0;
      end
      DS_BUSY: begin
        if (flush_i) state_d = DS_IDLE;
        else if (ds_done_i) begin
          state_d = DS_DONE;
          res_d   = ds_r_i;
        end else if (tmo) begin
          state_d = DS_IDLE;
          err_d   = 1'b1;
        end else cnt_d = cnt_q + TW'(1);
      end
      default: state_d = DS_IDLE;
    endcase
  end

  // Sequencer state, timeout counter, sticky error and result latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DS_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      res_q   <= res_d;
    end
  end

  assign state_o  = state_q;
  assign stall_o  = (state_q == DS_BUSY);
  assign ds_err_o = err_q;
  assign ds_res_o = res_q;
endmodule

// File: rtl/fpu_exec_pipe_ctrl.sv
// FP execute pipeline control: E1/E2/E3 stage registers, operand forwarding
// select, E3 result mux, and hazard feedback to decode.
// Optional feature macro: FPU_STALL_CNT_EN enables the saturating stall counter.
module fpu_exec_pipe_ctrl
  import fpu_pkg::*;
#(
  parameter int DS_TIMEOUT = 64,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fpu_en,
  input  logic             flush,
  input  logic             fasmds,
  input  logic             wf,
  input  logic [2:0]       fc,
  input  logic [4:0]       fd,
  input  logic [31:0]      qfa,
  input  logic [31:0]      qfb,
  input  logic             fwdfa,
  input  logic             fwdfb,
  output logic [31:0]      e1a,
  output logic [31:0]      e1b,
  output logic [2:0]       e1c,
  input  logic [31:0]      arith_r,
  output logic             ds_start,
  output logic             ds_abort,
  input  logic             ds_done,
  input  logic [31:0]      ds_r,
  output logic [4:0]       e1n,
  output logic [4:0]       e2n,
  output logic [4:0]       e3n,
  output logic             e1w,
  output logic             e2w,
  output logic             e3w,
  output logic [31:0]      e3d,
  output logic             stall_div_sqrt,
  output logic             ds_err,
  output logic [CNT_W-1:0] stall_cnt
);
  stage_t           e1_q, e1_d, e2_q, e2_d, e3_q, e3_d;
  logic [D_W-1:0]   e1a_q, e1a_d, e1b_q, e1b_d, ds_res;
  logic [FC_W-1:0]  e1c_q, e1c_d;
  ds_state_e        ds_state;
  logic             kill, adv, load, new_ds;

  fpu_divsqrt_seq #(.DS_TIMEOUT(DS_TIMEOUT)) u_seq (
    .clk       (clk),
    .rst_n     (rst_n),
    .e1_ds_i   (e1_q.ds),
    .flush_i   (flush),
    .ds_done_i (ds_done),
    .ds_r_i    (ds_r),
    .state_o   (ds_state),
    .ds_start_o(ds_start),
    .ds_abort_o(ds_abort),
    .kill_o    (kill),
    .stall_o   (stall_div_sqrt),
    .ds_err_o  (ds_err),
    .ds_res_o  (ds_res)
  );

  // E1 advances unless it holds a div/sqrt that has not reached DONE; a frozen
  // E1 sends bubbles into E2 while E2->E3 keeps draining.
  always_comb begin
    adv    = ~e1_q.ds | (ds_state == DS_DONE);
    load   = fpu_en & ~flush;
    new_ds = fasmds & is_ds(fc);
    e1_d   = e1_q;
    e1a_d  = e1a_q;
    e1b_d  = e1b_q;
    e1c_d  = e1c_q;
    e2_d   = '0;
    e3_d   = e2_q;
    if (adv) begin
      e2_d  = e1_q;
      e1_d  = '0;
      e1a_d = '0;
      e1b_d = '0;
      e1c_d = '0;
      if (load) begin
        e1_d.w  = wf & fasmds;
        e1_d.n  = fd;
        e1_d.ds = new_ds;
        e1_d.ar = fasmds & ~new_ds;
        e1a_d   = fwdfa ? e3d : qfa;
        e1b_d   = fwdfb ? e3d : qfb;
        e1c_d   = (fc > FC_SQRT) ? FC_ADD : fc;
      end
    end else if (kill) begin
      e1_d  = '0;
      e1a_d = '0;
      e1b_d = '0;
      e1c_d = '0;
    end
  end

  // Stage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e1_q  <= '0;
      e2_q  <= '0;
      e3_q  <= '0;
      e1a_q <= '0;
      e1b_q <= '0;
      e1c_q <= '0;
    end else begin
      e1_q  <= e1_d;
      e2_q  <= e2_d;
      e3_q  <= e3_d;
      e1a_q <= e1a_d;
      e1b_q <= e1b_d;
      e1c_q <= e1c_d;
    end
  end

  assign e3d = e3_q.ar ? arith_r : (e3_q.ds ? ds_res : '0);
  assign e1a = e1a_q;
  assign e1b = e1b_q;
  assign e1c = e1c_q;
  assign e1n = e1_q.n;
  assign e2n = e2_q.n;
  assign e3n = e3_q.n;
  assign e1w = e1_q.w;
  assign e2w = e2_q.w;
  assign e3w = e3_q.w;

`ifdef FPU_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Count stalled cycles, holding at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_div_sqrt && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_fpu_exec_pipe_ctrl.sv
// Self-checking bench for fpu_exec_pipe_ctrl: scoreboard of E3 write-backs
// plus cycle-accurate checks of div/sqrt sequencing.
module tb_fpu_exec_pipe_ctrl;
  localparam int DS_TO = 12;  // long enough for a 10-cycle div, short enough to time out quickly

  typedef struct {
    logic [4:0]  n;
    logic [31:0] d;
  } exp_t;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        fpu_en = 0, flush = 0, fasmds = 0, wf = 0, fwdfa = 0, fwdfb = 0, ds_done = 0;
  logic [2:0]  fc = 0;
  logic [4:0]  fd = 0;
  logic [31:0] qfa = 0, qfb = 0, ds_r = 0, arith_r, ar_next = 0;
  logic [2:0][31:0] ar_p = '0;
  logic [31:0] e1a, e1b, e3d;
  logic [2:0]  e1c;
  logic [4:0]  e1n, e2n, e3n;
  logic        e1w, e2w, e3w, ds_start, ds_abort, stall_div_sqrt, ds_err;
  logic [31:0] stall_cnt;

  int   n_chk = 0, n_err = 0;
  int   exp_stall = 0;
  exp_t sb[$];

  fpu_exec_pipe_ctrl #(.DS_TIMEOUT(DS_TO), .CNT_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .fpu_en(fpu_en), .flush(flush), .fasmds(fasmds), .wf(wf),
    .fc(fc), .fd(fd), .qfa(qfa), .qfb(qfb), .fwdfa(fwdfa), .fwdfb(fwdfb),
    .e1a(e1a), .e1b(e1b), .e1c(e1c), .arith_r(arith_r), .ds_start(ds_start),
    .ds_abort(ds_abort), .ds_done(ds_done), .ds_r(ds_r), .e1n(e1n), .e2n(e2n), .e3n(e3n),
    .e1w(e1w), .e2w(e2w), .e3w(e3w), .e3d(e3d), .stall_div_sqrt(stall_div_sqrt),
    .ds_err(ds_err), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // External 2-stage arith datapath model: result presented while the op sits in E3.
  always @(posedge clk) ar_p <= {ar_p[1:0], ar_next};
  assign arith_r = ar_p[2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [4:0] n, input logic [31:0] d);
    exp_t e;
    e.n = n;
    e.d = d;
    sb.push_back(e);
  endtask

  task automatic op(input logic fa, input logic w, input logic [2:0] c, input logic [4:0] d,
                    input logic [31:0] a, input logic [31:0] b, input logic fw,
                    input logic [31:0] ar);
    fpu_en = 1; fasmds = fa; wf = w; fc = c; fd = d;
    qfa = a; qfb = b; fwdfa = fw; fwdfb = 0; ar_next = ar;
  endtask

  task automatic bubble();
    fpu_en = 0; fasmds = 0; wf = 0; fc = 0; fd = 0; fwdfa = 0; ar_next = 0;
  endtask

  // Scoreboard: every E3 write-back must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && e3w) begin
      if (sb.size() == 0) chk("e3w_unexpected", {31'd0, e3w}, 32'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("e3n", {27'd0, e3n}, {27'd0, e.n});
        chk("e3d", e3d, e.d);
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_e3d", e3d, 0);
    chk("rst_stall", {31'd0, stall_div_sqrt}, 0);
    chk("rst_err", {31'd0, ds_err}, 0);
    chk("rst_e1w", {31'd0, e1w}, 0);
    chk("rst_e3w", {31'd0, e3w}, 0);
    chk("rst_start", {31'd0, ds_start}, 0);
    chk("rst_cnt", stall_cnt, 0);
    rst_n = 1;
    @(negedge clk);

    // add 1.0 + 2.0
    op(1, 1, 3'b000, 5, 32'h3f800000, 32'h40000000, 0, 32'h40400000);
    push(5, 32'h40400000);
    @(negedge clk); bubble();
    chk("add_e1n", {27'd0, e1n}, 5);
    chk("add_e1w", {31'd0, e1w}, 1);
    chk("add_e1a", e1a, 32'h3f800000);
    chk("add_e1b", e1b, 32'h40000000);
    chk("add_e1c", {29'd0, e1c}, 0);

    // sub into f3, then forward its E3 result into a mul
    op(1, 1, 3'b001, 3, 32'h40a00000, 32'h3f800000, 0, 32'h40800000);
    push(3, 32'h40800000);
    @(negedge clk); bubble();
    @(negedge clk);
    @(negedge clk);
    op(1, 1, 3'b010, 4, 32'hdeadbeef, 32'h40000000, 1, 32'h41000000);
    push(4, 32'h41000000);
    @(negedge clk); bubble();
    chk("fwd_e1a", e1a, 32'h40800000);
    chk("fwd_e1b", e1b, 32'h40000000);
    chk("mul_e1c", {29'd0, e1c}, 2);

    // unknown fc behaves as add
    op(1, 1, 3'b110, 9, 32'h1, 32'h2, 0, 32'h12345678);
    push(9, 32'h12345678);
    @(negedge clk); bubble();
    chk("unk_e1c", {29'd0, e1c}, 0);
    chk("unk_e1n", {27'd0, e1n}, 9);

    // arith op without write, then write without arith: neither writes
    op(1, 0, 3'b000, 11, 32'h0, 32'h0, 0, 32'h0);
    @(negedge clk);
    chk("nowf_e1w", {31'd0, e1w}, 0);
    chk("nowf_e1n", {27'd0, e1n}, 11);
    op(0, 1, 3'b000, 12, 32'h0, 32'h0, 0, 32'h0);
    @(negedge clk);
    chk("nofa_e1w", {31'd0, e1w}, 0);

    // flush while idle turns the incoming op into a bubble
    op(1, 1, 3'b000, 13, 32'h5, 32'h6, 0, 32'h0);
    flush = 1;
    @(negedge clk); bubble(); flush = 0;
    chk("flush_e1w", {31'd0, e1w}, 0);
    chk("flush_e1n", {27'd0, e1n}, 0);
    repeat (3) @(negedge clk);

    // 10-cycle div into f7
    op(1, 1, 3'b011, 7, 32'h41200000, 32'h40000000, 0, 32'h0);
    push(7, 32'h40a00001);
    @(negedge clk); bubble();
    chk("div_start", {31'd0, ds_start}, 1);
    chk("div_stall0", {31'd0, stall_div_sqrt}, 0);
    chk("div_e1c", {29'd0, e1c}, 3);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      chk("div_stall", {31'd0, stall_div_sqrt}, 1);
      chk("div_start_once", {31'd0, ds_start}, 0);
      if (k == 10) begin ds_done = 1; ds_r = 32'h40a00001; end
    end
    exp_stall += 10;
    @(negedge clk);
    chk("div_done_stall", {31'd0, stall_div_sqrt}, 0);
    ds_done = 1; ds_r = 32'hbad0bad0;  // outside BUSY: must be ignored
    @(negedge clk); ds_done = 0;
    chk("div_e3w_early", {31'd0, e3w}, 0);
    chk("div_idle_stall", {31'd0, stall_div_sqrt}, 0);
    @(negedge clk);
    chk("div_e3w", {31'd0, e3w}, 1);
`ifdef FPU_STALL_CNT_EN
    chk("div_cnt", stall_cnt, exp_stall);
`else
    chk("div_cnt", stall_cnt, 0);
`endif

    // flush mid-div with a coincident ds_done: abort wins, nothing written
    op(1, 1, 3'b011, 10, 32'h1, 32'h2, 0, 32'h0);
    @(negedge clk); bubble();
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("fl_stall", {31'd0, stall_div_sqrt}, 1);
      if (k == 4) begin
        flush = 1; ds_done = 1; ds_r = 32'h77777777;
        #1 chk("fl_abort", {31'd0, ds_abort}, 1);
      end
    end
    exp_stall += 4;
    @(negedge clk); flush = 0; ds_done = 0;
    chk("fl_stall_drop", {31'd0, stall_div_sqrt}, 0);
    chk("fl_err", {31'd0, ds_err}, 0);
    chk("fl_e1w", {31'd0, e1w}, 0);
    repeat (3) @(negedge clk);

    // sqrt that never completes: times out after DS_TO busy cycles
    op(1, 1, 3'b100, 8, 32'h40800000, 32'h0, 0, 32'h0);
    @(negedge clk); bubble();
    chk("to_start", {31'd0, ds_start}, 1);
    for (int k = 1; k <= DS_TO; k++) begin
      @(negedge clk);
      chk("to_stall", {31'd0, stall_div_sqrt}, 1);
      chk("to_abort", {31'd0, ds_abort}, (k == DS_TO) ? 32'd1 : 32'd0);
    end
    exp_stall += DS_TO;
    @(negedge clk);
    chk("to_stall_drop", {31'd0, stall_div_sqrt}, 0);
    chk("to_err", {31'd0, ds_err}, 1);
    chk("to_e1w", {31'd0, e1w}, 0);
    chk("to_abort_once", {31'd0, ds_abort}, 0);
    repeat (4) @(negedge clk);
    chk("err_sticky", {31'd0, ds_err}, 1);
`ifdef FPU_STALL_CNT_EN
    chk("end_cnt", stall_cnt, exp_stall);
`else
    chk("end_cnt", stall_cnt, 0);
`endif
    chk("sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
